uart_sender: RTL
================

Name: uart_sender

Overview:
- UART transmitter, the transmit-side counterpart of the team's 16x-oversampled UART receiver.
- Serialises one byte per request onto UART_TX: 1 start bit (0), DATA_BITS data bits LSB first, STOP_BITS stop bits (1).
- Shares the receiver's sampleclk, so each bit lasts exactly OVERSAMPLE sampleclk cycles.
- Sits between the CPU's UART peripheral registers and the TX pin.

Parameters:
- OVERSAMPLE, 16: sampleclk cycles per bit; legal range 2..255.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.

Ports:
- reset  input  1: asynchronous, active-low reset.
- sampleclk  input  1: oversampling clock, rising-edge active.
- TX_DATA  input  8: byte to send. Bits above DATA_BITS-1 are ignored.
- TX_EN  input  1: send request, sampled on sampleclk rising edge.
- TX_STATUS  output  1: 1 = idle and ready, 0 = frame in progress.
- TX_DONE  output  1: one-cycle pulse when the last stop bit completes.
- UART_TX  output  1: serial line, idles high.

Behaviour:
- Reset (asynchronous, active-low): effective immediately, including mid-frame; the partial frame is abandoned.
  - UART_TX=1, TX_STATUS=1, TX_DONE=0.
  - State=IDLE, bit counter=0, cycle counter=0, shift register=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, STOP (plus PARITY when enabled).
- IDLE:
  - UART_TX=1, TX_STATUS=1.
  - On an edge (call it k) where TX_EN=1: latch TX_DATA into the shift register; UART_TX<=0; TX_STATUS<=0; cycle counter<=0; go to START.
  - TX_EN=0: remain in IDLE.
- Cycle counter: counts 0..OVERSAMPLE-1 within each bit. The bit ends when the counter reaches OVERSAMPLE-1; the next bit value is driven on that edge.
- START: UART_TX=0 for OVERSAMPLE cycles, then drive data bit 0 and go to DATA.
- DATA:
  - Bit i is driven after edge k+OVERSAMPLE*(1+i), for i=0..DATA_BITS-1.
  - Shift right one bit per bit period.
  - After bit DATA_BITS-1: UART_TX<=1, go to STOP.
- STOP:
  - UART_TX=1 for OVERSAMPLE*STOP_BITS cycles.
  - On the final edge: go to IDLE, TX_STATUS<=1, TX_DONE<=1.
- TX_DONE is high for exactly one cycle, coincident with the first IDLE cycle.
- Frame length with defaults: 160 cycles from edge k to TX_STATUS rising (OVERSAMPLE*(1+DATA_BITS+STOP_BITS)).
- TX_EN while TX_STATUS=0: ignored. No queuing; TX_DATA changes mid-frame have no effect.
- TX_EN held high continuously: the next frame is accepted on the first IDLE edge. This gives exactly one idle-high sampleclk cycle between frames.
- Simultaneous TX_DONE and new TX_EN: TX_EN is sampled in the IDLE cycle, i.e. the cycle where TX_DONE=1, and accepted at that edge.
- Counters must be wide enough for OVERSAMPLE*2 without wrap. No counter wraps during a legal frame.

Optional Feature:
- Macro: UART_SENDER_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - UART_TX drives even parity (XOR of the DATA_BITS data bits) for OVERSAMPLE cycles.
  - Default frame = 176 cycles.
- Undefined: no PARITY state, no parity logic; frame as above.

Test Plan:
- Reset released, TX_EN=0 for 50 cycles -> UART_TX=1, TX_STATUS=1, TX_DONE=0 throughout.
- TX_DATA=0xA3, one-cycle TX_EN pulse -> UART_TX segments of 16 cycles each: 0, 1,1,0,0,0,1,0,1, then 1. TX_STATUS=0 for 160 cycles, then TX_DONE pulses once.
- TX_DATA=0x55 with TX_EN held high for 400 cycles -> two complete frames, separated by exactly one idle-high cycle, each followed by a TX_DONE pulse.
- Mid-frame, at cycle 40, TX_DATA changed to 0xFF and TX_EN pulsed -> the original byte is transmitted unchanged; no second frame starts.
- reset asserted at cycle 70 of a frame -> UART_TX=1 and TX_STATUS=1 immediately (asynchronous). After release, a new TX_EN=1 with 0x00 sends a clean frame.
- With UART_SENDER_PARITY_EN: 0x07 -> parity bit 1; 0x03 -> parity bit 0. Frame is 176 cycles; the stop bit begins at cycle 160.

Source files
------------

// File: rtl/uart_sender.sv
// uart_sender: UART transmitter that shares the 16x-oversampled receiver's sampleclk.
// Each frame is 1 start bit, DATA_BITS data bits sent LSB first, and STOP_BITS stop bits.
// Every bit lasts exactly OVERSAMPLE sampleclk cycles.
// Optional feature macro: UART_SENDER_PARITY_EN inserts an even-parity bit after the data bits.
module uart_sender #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1
) (
   input  logic       reset,
   input  logic       sampleclk,
   input  logic [7:0] TX_DATA,
   input  logic       TX_EN,
   output logic       TX_STATUS,
   output logic       TX_DONE,
   output logic       UART_TX
);

   // Sized so that a two-stop-bit period (2*OVERSAMPLE cycles) never wraps.
   localparam int CNT_W = $clog2(2 * OVERSAMPLE + 1);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(OVERSAMPLE * STOP_BITS - 1);
   localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
   localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_SENDER_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cyc_cnt_r;
   logic [2:0]       bit_cnt_r;
   logic [7:0]       shift_r;
   logic             tx_r;
   logic             status_r;
   logic             done_r;

`ifdef UART_SENDER_PARITY_EN
   logic             parity_r;

   // Even parity over the data bits that are actually transmitted.
   function automatic logic even_parity(input logic [7:0] data);
      return ^(data & DATA_MASK);
   endfunction
`endif

   // Frame sequencer: state, per-bit cycle counter, data shifter and registered outputs.
   always_ff @(posedge sampleclk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         cyc_cnt_r <= '0;
         bit_cnt_r <= 3'd0;
         shift_r   <= 8'h00;
         tx_r      <= 1'b1;
         status_r  <= 1'b1;
         done_r    <= 1'b0;
`ifdef UART_SENDER_PARITY_EN
         parity_r  <= 1'b0;
`endif
      end else begin
         // TX_DONE is a single-cycle pulse; only the final stop edge raises it.
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (TX_EN) begin
                  // Latch the byte now; later TX_DATA changes cannot affect this frame.
                  shift_r   <= TX_DATA & DATA_MASK;
`ifdef UART_SENDER_PARITY_EN
                  parity_r  <= even_parity(TX_DATA);
`endif
                  tx_r      <= 1'b0;
                  status_r  <= 1'b0;
                  cyc_cnt_r <= '0;
                  bit_cnt_r <= 3'd0;
                  state_r   <= ST_START;
               end else begin
                  tx_r     <= 1'b1;
                  status_r <= 1'b1;
                  state_r  <= ST_IDLE;
               end
            end
            ST_START: begin
               if (cyc_cnt_r == BIT_LAST) begin
                  cyc_cnt_r <= '0;
                  tx_r      <= shift_r[0];
                  shift_r   <= {1'b0, shift_r[7:1]};
                  bit_cnt_r <= 3'd0;
                  state_r   <= ST_DATA;
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + 1'b1;
               end
            end
            ST_DATA: begin
               if (cyc_cnt_r == BIT_LAST) begin
                  cyc_cnt_r <= '0;
                  if (bit_cnt_r == DATA_LAST) begin
`ifdef UART_SENDER_PARITY_EN
                     tx_r    <= parity_r;
                     state_r <= ST_PARITY;
`else
                     tx_r    <= 1'b1;
                     state_r <= ST_STOP;
`endif
                  end else begin
                     tx_r      <= shift_r[0];
                     shift_r   <= {1'b0, shift_r[7:1]};
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + 1'b1;
               end
            end
`ifdef UART_SENDER_PARITY_EN
            ST_PARITY: begin
               if (cyc_cnt_r == BIT_LAST) begin
                  cyc_cnt_r <= '0;
                  tx_r      <= 1'b1;
                  state_r   <= ST_STOP;
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (cyc_cnt_r == STOP_LAST) begin
                  cyc_cnt_r <= '0;
                  tx_r      <= 1'b1;
                  status_r  <= 1'b1;
                  done_r    <= 1'b1;
                  state_r   <= ST_IDLE;
               end else begin
                  cyc_cnt_r <= cyc_cnt_r + 1'b1;
               end
            end
            default: begin
               cyc_cnt_r <= '0;
               tx_r      <= 1'b1;
               status_r  <= 1'b1;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

   assign UART_TX   = tx_r;
   assign TX_STATUS = status_r;
   assign TX_DONE   = done_r;

endmodule
